// File: rtl/ifu_pkg.sv
// ifu_pkg: shared defaults and FIFO entry type for the instruction fetch unit
package ifu_pkg;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam logic [DEF_ADDR_WIDTH-1:0] DEF_RESET_VECTOR = 8'h00;
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_DATA_WIDTH-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/ifu_prefetch_fifo.sv
// ifu_prefetch_fifo: circular prefetch FIFO with push, pop, flush and occupancy
// Ports: clk, rst_n (async, active-low), push_i/wdata_i write side,
//        pop_i/rdata_o read side (rdata_o is the head entry), flush_i empties
//        the FIFO with priority over push/pop, occ_o is the entry count.
module ifu_prefetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_ADDR_WIDTH + DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [OW-1:0] occ_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_i) rd_q <= inc(rd_q);
      occ_q <= occ_q + OW'(push_i) - OW'(pop_i);
    end
  end
  assign rdata_o = mem_q[rd_q];
  assign occ_o   = occ_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program-ROM fetch initiator with prefetch FIFO and redirect
// Ports: clk, rst_n (async, active-low); rom_addr_o/rom_data_i ROM bus (data
//        one cycle after address); instr_o/instr_pc_o/instr_valid_o/
//        instr_ready_i decoder handshake; redirect_i/redirect_addr_i flush and
//        restart; stall_cnt_o empty-cycle counter, present only with IFU_PERF_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i
`ifdef IFU_PERF_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d, pop, issue;
  logic [$clog2(FIFO_DEPTH+1)-1:0] occ;
  // The in-flight byte reserves a slot so a push can never find the FIFO full.
  assign pop   = instr_valid_o & instr_ready_i;
  assign issue = !redirect_i && (int'(occ) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
  always_comb begin
    fetch_pc_d    = redirect_i ? redirect_addr_i : issue ? fetch_pc_q + 1'b1 : fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_VECTOR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
  ifu_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i ({inflight_pc_q, rom_data_i}),
    .rdata_o ({instr_pc_o, instr_o}),
    .occ_o   (occ)
  );
  assign rom_addr_o    = fetch_pc_q;
  assign instr_valid_o = occ != '0;
`ifdef IFU_PERF_EN
  logic [1:0] redir_q;
  logic [15:0] stall_q;
  // Empty cycles caused by the redirect refill bubble are not counted as stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_q <= '0;
      stall_q <= '0;
    end else begin
      redir_q <= {redir_q[0], redirect_i};
      if (!instr_valid_o && redir_q == 2'b00 && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end
  assign stall_cnt_o = stall_q;
`endif
endmodule
